// File: rtl/seq_stage_controller.sv
// seq_stage_controller: multi-cycle sequencer for the Y86-64 SEQ datapath.
// Steps Fetch, Decode, Execute, Memory, Writeback and PC-update one stage per clock
// with one-hot stage enables, runs continuously (run) or single-steps (step), waits on
// a data-memory ready handshake, latches the architectural status and freezes in HALT
// on any non-AOK status.
//
// Parameters:
//   MEM_TIMEOUT  max MEM_WAIT cycles before a forced ADR halt (0 disables the timeout)
//   CNT_W        performance counter width (only with SEQ_PERF_CNT_EN)
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   run, step          continuous run level, single-step request (sampled in IDLE)
//   status_in          datapath status: 00 AOK, 01 HLT, 10 ADR, 11 INS
//   mem_access         current instruction uses data memory (sampled in EXECUTE)
//   mem_ready          data memory completion, valid while mem_req=1
//   mem_req            data memory request
//   en_*               one-hot stage enables
//   instr_done         one-cycle retire pulse
//   stat               latched status
//   halted, busy       controller in HALT, instruction in flight
// Optional feature (macro SEQ_PERF_CNT_EN): cycle_cnt / retired_cnt counters.
module seq_stage_controller #(
  parameter int unsigned MEM_TIMEOUT = 15
`ifdef SEQ_PERF_CNT_EN
  ,
  parameter int unsigned CNT_W = 32
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       step,
  input  logic [1:0] status_in,
  input  logic       mem_access,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       en_fetch,
  output logic       en_decode,
  output logic       en_execute,
  output logic       en_mem,
  output logic       en_wb,
  output logic       en_pc,
  output logic       instr_done,
  output logic [1:0] stat,
  output logic       halted,
  output logic       busy
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retired_cnt
`endif
);

  localparam int unsigned TimerW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  typedef enum logic [3:0] {
    StIdle,
    StFetch,
    StDecode,
    StExecute,
    StMemory,
    StMemWait,
    StWriteback,
    StPcUpd,
    StHalt
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        stat_q, stat_d;
  logic [TimerW-1:0] wait_q, wait_d;
  // {fetch, decode, execute, mem, wb, pc, mem_req, instr_done, halted, busy}
  logic [9:0]        outs_q;
  logic              timeout_hit;

  // Outputs are registered from the next state so they always equal a decode of state_q.
  function automatic logic [9:0] decode_outs(input state_e s);
    case (s)
      StFetch:              decode_outs = 10'b1000000001;
      StDecode:             decode_outs = 10'b0100000001;
      StExecute:            decode_outs = 10'b0010000001;
      StMemory, StMemWait:  decode_outs = 10'b0001001001;
      StWriteback:          decode_outs = 10'b0000100001;
      StPcUpd:              decode_outs = 10'b0000010101;
      StHalt:               decode_outs = 10'b0000000010;
      default:              decode_outs = 10'b0000000000;
    endcase
  endfunction

  // Compares the post-increment count so the halt lands on the MEM_TIMEOUT-th wait cycle.
  assign timeout_hit = (MEM_TIMEOUT != 0) && ((32'(wait_q) + 32'd1) >= MEM_TIMEOUT);

  always_comb begin
    state_d = state_q;
    stat_d  = stat_q;
    wait_d  = wait_q;
    case (state_q)
      StIdle:    if (run || step) state_d = StFetch;
      StFetch: begin
        if (status_in != 2'b00) begin
          state_d = StHalt;
          stat_d  = status_in;
        end else begin
          state_d = StDecode;
        end
      end
      StDecode:  state_d = StExecute;
      StExecute: state_d = mem_access ? StMemory : StWriteback;
      StMemory, StMemWait: begin
        wait_d = (state_q == StMemory) ? '0 : wait_q + TimerW'(1);
        if (mem_ready) begin
          // Ready beats a coinciding timeout; an ADR status on completion still halts.
          if (status_in == 2'b10) begin
            state_d = StHalt;
            stat_d  = 2'b10;
          end else begin
            state_d = StWriteback;
          end
        end else if (state_q == StMemory) begin
          state_d = StMemWait;
        end else if (timeout_hit) begin
          state_d = StHalt;
          stat_d  = 2'b10;
        end
      end
      StWriteback: state_d = StPcUpd;
      StPcUpd: begin
        stat_d  = 2'b00;
        state_d = run ? StFetch : StIdle;
      end
      StHalt:  state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      stat_q  <= 2'b00;
      wait_q  <= '0;
      outs_q  <= '0;
    end else begin
      state_q <= state_d;
      stat_q  <= stat_d;
      wait_q  <= wait_d;
      outs_q  <= decode_outs(state_d);
    end
  end

  assign {en_fetch, en_decode, en_execute, en_mem, en_wb, en_pc,
          mem_req, instr_done, halted, busy} = outs_q;
  assign stat = stat_q;

`ifdef SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_q, retired_cnt_q;

  // Both counters naturally freeze in HALT since busy and instr_done are low there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt_q   <= '0;
      retired_cnt_q <= '0;
    end else begin
      if (busy)       cycle_cnt_q   <= cycle_cnt_q + CNT_W'(1);
      if (instr_done) retired_cnt_q <= retired_cnt_q + CNT_W'(1);
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign retired_cnt = retired_cnt_q;
`endif

endmodule

// File: doc/seq_stage_controller.md
Name: seq_stage_controller

Overview:
- Multi-cycle sequencer for the Y86-64 SEQ datapath. Steps Fetch, Decode, Execute, Memory, Writeback and PC-update one stage per clock, using one-hot stage enables.
- Runs continuously or single-steps. Waits on a data-memory ready handshake.
- Latches the architectural status (AOK/HLT/ADR/INS) and freezes the datapath on any non-AOK status. The PC is never advanced for a faulting instruction.

Parameters:
- MEM_TIMEOUT, 15: max MEM_WAIT cycles before a forced ADR; 0 disables the timeout.
- CNT_W, 32: width of the performance counters (optional feature only).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- run  input  1  level; while high, instructions execute back-to-back
- step  input  1  sampled in IDLE; starts exactly one instruction when run=0
- status_in  input  2  datapath status: 00 AOK, 01 HLT, 10 ADR, 11 INS
- mem_access  input  1  current instruction uses data memory (decoded icode); sampled in EXECUTE
- mem_ready  input  1  data memory completion, valid while mem_req=1
- mem_req  output  1  data memory request
- en_fetch, en_decode, en_execute, en_mem, en_wb, en_pc  output  1 each  stage enables
- instr_done  output  1  one-cycle pulse, instruction retired
- stat  output  2  latched status, same encoding as status_in
- halted  output  1  controller in HALT
- busy  output  1  instruction in flight

Behaviour:
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, MEM_WAIT, WRITEBACK, PCUPD, HALT.
- All outputs are Moore, decoded from the registered state only. At most one en_* is high in any cycle.
- Reset (async, immediate):
  - state=IDLE, wait counter 0.
  - All outputs 0: en_*, mem_req, instr_done, stat=00, halted, busy.
- busy is 1 in every state except IDLE and HALT.
- IDLE: go to FETCH if run|step, else stay.
- FETCH: en_fetch=1.
  - If status_in != 00 at the end of the cycle: go to HALT, stat<=status_in.
  - Otherwise go to DECODE.
- DECODE: en_decode=1, go to EXECUTE.
- EXECUTE: en_execute=1. Go to MEMORY if mem_access=1, else WRITEBACK.
- MEMORY: en_mem=1, mem_req=1, wait counter cleared.
  - If mem_ready=1: complete (below).
  - Else: go to MEM_WAIT.
- MEM_WAIT: en_mem=1, mem_req=1, counter increments every cycle.
  - If mem_ready=1: complete.
  - Else if MEM_TIMEOUT!=0 and the counter reaches MEM_TIMEOUT: go to HALT, stat<=10.
  - If ready and timeout coincide, ready wins.
- Memory completion: if status_in=10, go to HALT with stat<=10; otherwise go to WRITEBACK.
- WRITEBACK: en_wb=1, go to PCUPD.
- PCUPD: en_pc=1, instr_done=1, stat<=00.
  - Go to FETCH if run=1, else IDLE.
  - Deasserting run mid-instruction finishes that instruction, then the controller idles.
- HALT: all en_*, mem_req and busy are 0; halted=1; stat held.
  - run and step are ignored. Only rst exits HALT.
- Latency:
  - Non-memory instruction: 5 cycles.
  - Memory instruction with mem_ready in the MEMORY cycle: 6 cycles.
  - Each extra wait cycle adds 1.
- rst mid-instruction abandons the instruction: no en_pc, no instr_done.

Optional Feature:
- Macro SEQ_PERF_CNT_EN.
- When defined, adds two CNT_W-bit outputs, both reset to 0, both frozen in HALT, both wrapping modulo 2^CNT_W:
  - cycle_cnt: increments every cycle busy=1.
  - retired_cnt: increments on each instr_done.
- When undefined, these ports and their logic are absent. All other behaviour is identical.

Test Plan:
- Run stream: rst, then run=1, mem_access=0, status_in=00 -> enables cycle F,D,E,W,P repeatedly; instr_done every 5th cycle; stat=00.
- Memory wait: mem_access=1, mem_ready high 3 cycles after mem_req rises -> mem_req high 4 cycles; instruction takes 9 cycles; one instr_done.
- Halt: status_in=01 during FETCH -> next cycle halted=1, stat=01, busy=0, en_pc never asserted; state stays HALT with run=1 for 20 cycles.
- Timeout: MEM_TIMEOUT=4, mem_ready stuck 0 -> MEMORY plus 4 MEM_WAIT cycles, then halted=1, stat=10, mem_req=0.
- Single-step: run=0, one-cycle step pulse -> exactly one instr_done, then IDLE, busy=0, no further en_fetch.
- Async reset: assert rst during EXECUTE, between clock edges -> all outputs 0 immediately; after release with run=1, next instruction starts at FETCH.
- With SEQ_PERF_CNT_EN: 3 non-memory instructions -> retired_cnt=3, cycle_cnt=15.
